// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled: 2-flop synchronizer, start-bit validation at bit centre,
// LSB-first data, optional even parity, 1 or 2 stop bits, registered result with done strobe.
module uart_rx #(
    parameter int NO_OF_BITS    = 8,
    parameter int PARITY_ENABLE = 0,
    parameter int STOP_BIT      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  rx,
    output logic [NO_OF_BITS-1:0] rx_dout,
    output logic                  rx_done,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  rx_busy
);
    localparam int BW = (NO_OF_BITS < 2) ? 1 : $clog2(NO_OF_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, state_n;
    logic                    rx_meta, rxs;
    logic [3:0]              tcnt, tcnt_n;
    logic [BW-1:0]           bcnt, bcnt_n;
    logic [NO_OF_BITS-1:0]   sr, sr_n, sr_sh;
    logic                    stop2, stop2_n;
    logic                    perr, perr_n;
    logic                    ferr, ferr_n;
    logic                    done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // New bit enters at the MSB so the first-received bit ends up at bit 0.
    if (NO_OF_BITS == 1) begin : g_one
        assign sr_sh = rxs;
    end else begin : g_many
        assign sr_sh = {rxs, sr[NO_OF_BITS-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            sr    <= '0;
            stop2 <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            bcnt  <= bcnt_n;
            sr    <= sr_n;
            stop2 <= stop2_n;
            perr  <= perr_n;
            ferr  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        bcnt_n  = bcnt;
        sr_n    = sr;
        stop2_n = stop2;
        perr_n  = perr;
        ferr_n  = ferr;
        done_n  = 1'b0;
        if (tick) begin
            case (state)
                IDLE: if (!rxs) begin
                    tcnt_n  = '0;
                    bcnt_n  = '0;
                    stop2_n = 1'b0;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                    state_n = START;
                end
                START: if (tcnt == 4'd6) begin
                    tcnt_n  = '0;
                    state_n = rxs ? IDLE : DATA;
                end else begin
                    tcnt_n = tcnt + 4'd1;
                end
                DATA: if (tcnt == 4'd15) begin
                    tcnt_n = '0;
                    sr_n   = sr_sh;
                    bcnt_n = bcnt + BW'(1);
                    if (bcnt == BW'(NO_OF_BITS - 1))
                        state_n = (PARITY_ENABLE != 0) ? PARITY : STOP;
                end else begin
                    tcnt_n = tcnt + 4'd1;
                end
                PARITY: if (tcnt == 4'd15) begin
                    tcnt_n  = '0;
                    perr_n  = rxs ^ (^sr);
                    state_n = STOP;
                end else begin
                    tcnt_n = tcnt + 4'd1;
                end
                STOP: if (tcnt == 4'd15) begin
                    tcnt_n = '0;
                    ferr_n = ferr | ~rxs;
                    if (STOP_BIT == 0 && !stop2) begin
                        stop2_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    tcnt_n = tcnt + 4'd1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Results are captured on the final stop-sample edge and held until the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_dout    <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done <= done_n;
            if (done_n) begin
                rx_dout    <= sr;
                parity_err <= perr;
                frame_err  <= ferr_n;
            end
        end
    end

    assign rx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (8N1, 8E1, 8N2), a bit-level serial driver, and a
// scoreboard that checks data, flags and strobe timing whenever rx_done fires.
`timescale 1ns/1ps
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] div = '0;
    logic [2:0] rxl = '1;

    logic [7:0] dout [3];
    logic       done [3];
    logic       pe   [3];
    logic       fe   [3];
    logic       busy [3];

    int unsigned tick_cnt = 0;
    int unsigned since = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        int unsigned due;
    } exp_t;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    // One-clk tick every 4 clks.
    always @(posedge clk) begin
        div  <= div + 2'd1;
        tick <= (div == 2'd2);
    end

    always @(posedge clk) begin
        if (tick) begin
            tick_cnt <= tick_cnt + 1;
            since    <= 0;
        end else begin
            since <= since + 1;
        end
    end

    uart_rx #(.NO_OF_BITS(8), .PARITY_ENABLE(0), .STOP_BIT(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rxl[0]), .rx_dout(dout[0]),
        .rx_done(done[0]), .parity_err(pe[0]), .frame_err(fe[0]), .rx_busy(busy[0]));
    uart_rx #(.NO_OF_BITS(8), .PARITY_ENABLE(1), .STOP_BIT(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rxl[1]), .rx_dout(dout[1]),
        .rx_done(done[1]), .parity_err(pe[1]), .frame_err(fe[1]), .rx_busy(busy[1]));
    uart_rx #(.NO_OF_BITS(8), .PARITY_ENABLE(0), .STOP_BIT(0)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rxl[2]), .rx_dout(dout[2]),
        .rx_done(done[2]), .parity_err(pe[2]), .frame_err(fe[2]), .rx_busy(busy[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done strobe must match the oldest pending frame.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (done[s] === 1'b1) begin
                exp_t e;
                logic ok;
                ok = 1'b1;
                e  = '{8'h00, 1'b0, 1'b0, 0};
                case (s)
                    0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
                    1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
                    default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
                endcase
                check($sformatf("done_expected[%0d]", s), {31'b0, ok}, 32'd1);
                if (ok) begin
                    check($sformatf("rx_dout[%0d]", s), {24'b0, dout[s]}, {24'b0, e.d});
                    check($sformatf("parity_err[%0d]", s), {31'b0, pe[s]}, {31'b0, e.pe});
                    check($sformatf("frame_err[%0d]", s), {31'b0, fe[s]}, {31'b0, e.fe});
                    check($sformatf("done_tick[%0d]", s), tick_cnt, e.due);
                    check($sformatf("done_cycle[%0d]", s), since, 32'd0);
                end
            end
        end
    end

    // Advance to the negedge just after the next tick edge.
    task automatic wait_tick();
        @(negedge clk);
        while (since != 0) @(negedge clk);
    endtask

    // Drives n bits (bit 0 = start bit) at 16 ticks each; the last bit lasts last_ticks.
    task automatic send_frame(input int sel, input logic [15:0] bits, input int n,
                              input int last_ticks, input logic [7:0] d,
                              input logic xpe, input logic xfe);
        exp_t e;
        if (since != 0) wait_tick();
        e.d   = d;
        e.pe  = xpe;
        e.fe  = xfe;
        e.due = tick_cnt + 1 + 7 + 16 * (n - 1);
        case (sel)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        for (int i = 0; i < n; i++) begin
            rxl[sel] = bits[i];
            repeat ((i == n - 1) ? last_ticks : 16) wait_tick();
        end
        rxl[sel] = 1'b1;
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic s);
        return {6'b0, s, d, 1'b0};
    endfunction
    function automatic logic [15:0] f8e1(input logic [7:0] d, input logic p);
        return {5'b0, 1'b1, p, d, 1'b0};
    endfunction
    function automatic logic [15:0] f8n2(input logic [7:0] d, input logic s1, input logic s2);
        return {5'b0, s2, s1, d, 1'b0};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_dout"}, {24'b0, dout[0]}, 32'd0);
        check({tag, "_done"}, {31'b0, done[0]}, 32'd0);
        check({tag, "_perr"}, {31'b0, pe[0]}, 32'd0);
        check({tag, "_ferr"}, {31'b0, fe[0]}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy[0]}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (4) wait_tick();

        // 8N1 back-to-back, zero idle gap
        send_frame(0, f8n1(8'hA5, 1'b1), 10, 16, 8'hA5, 1'b0, 1'b0);
        send_frame(0, f8n1(8'h3C, 1'b1), 10, 16, 8'h3C, 1'b0, 1'b0);
        repeat (4) wait_tick();

        // Even parity: 0x0F has four ones, so parity bit 0 is correct
        send_frame(1, f8e1(8'h0F, 1'b0), 11, 16, 8'h0F, 1'b0, 1'b0);
        send_frame(1, f8e1(8'h0F, 1'b1), 11, 16, 8'h0F, 1'b1, 1'b0);
        repeat (4) wait_tick();

        // Two stop bits: second low, then both high
        send_frame(2, f8n2(8'h81, 1'b1, 1'b0), 11, 8, 8'h81, 1'b0, 1'b1);
        repeat (4) wait_tick();
        send_frame(2, f8n2(8'h81, 1'b1, 1'b1), 11, 16, 8'h81, 1'b0, 1'b0);
        repeat (4) wait_tick();

        // False start: 3-tick glitch
        rxl[0] = 1'b0;
        repeat (3) wait_tick();
        rxl[0] = 1'b1;
        check("glitch_busy_T2", {31'b0, busy[0]}, 32'd1);
        repeat (5) wait_tick();
        check("glitch_busy_T7", {31'b0, busy[0]}, 32'd0);
        repeat (8) wait_tick();

        // Framing error: stop low, released just after its sample
        send_frame(0, f8n1(8'h55, 1'b0), 10, 8, 8'h55, 1'b0, 1'b1);
        repeat (8) wait_tick();

        // Reset in the middle of data bit 4 of 0xFF
        rxl[0] = 1'b0;
        repeat (16) wait_tick();
        rxl[0] = 1'b1;
        repeat (16 * 4 + 8) wait_tick();
        check("midframe_busy", {31'b0, busy[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) wait_tick();
        send_frame(0, f8n1(8'h12, 1'b1), 10, 16, 8'h12, 1'b0, 1'b0);

        // Random stream from a bench-side transmitter
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) wait_tick();
            send_frame(0, f8n1(b, 1'b1), 10, 16, b, 1'b0, 1'b0);
        end

        repeat (20) wait_tick();
        check("pending_8n1", q0.size(), 32'd0);
        check("pending_8e1", q1.size(), 32'd0);
        check("pending_8n2", q2.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
